// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the PE-to-router ingress path.
//   FLIT_W            : flit width in bits
//   DEST_HI..DEST_LO  : destination field inside a flit
//   PAYLOAD_W         : payload width (low bits of the flit)
//   NUM_PE            : number of addressable processing elements
//   flit_class_e      : where a head flit goes (router, loopback, discard)
//   classify()        : maps a destination to its flit class
// -----------------------------------------------------------------------------
package noc_pkg;

  localparam int FLIT_W    = 32;
  localparam int DEST_HI   = 31;
  localparam int DEST_LO   = 24;
  localparam int PAYLOAD_W = 24;
  localparam int NUM_PE    = 16;
  localparam int DEST_W    = FLIT_W - PAYLOAD_W;

  typedef enum logic [1:0] {
    NET  = 2'd0,
    LOOP = 2'd1,
    DROP = 2'd2
  } flit_class_e;

  // Out-of-range destinations are discarded before the self-address check,
  // so a PE whose own address is out of range never loops anything back.
  function automatic flit_class_e classify(input logic [DEST_W-1:0] dest,
                                           input int address,
                                           input int num_pe);
    flit_class_e cls;
    if (int'(dest) >= num_pe) begin
      cls = DROP;
    end else if (int'(dest) == address) begin
      cls = LOOP;
    end else begin
      cls = NET;
    end
    return cls;
  endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// -----------------------------------------------------------------------------
// noc_flit_fifo
// Synchronous FIFO with valid/ready on both sides and a combinational head.
//   clk       : clock
//   rst       : asynchronous active-low reset (clears pointers and occupancy)
//   in_data   : write data
//   in_valid  : write request
//   in_ready  : not full; a write happens when in_valid && in_ready
//   out_data  : head entry (meaningful only while out_valid)
//   out_valid : not empty
//   out_ready : consumer takes the head; a read happens when both are high
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module noc_flit_fifo
  import noc_pkg::*;
#(
  parameter int WIDTH = FLIT_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);

  // Readiness is based on the registered full flag only: a pop in the same
  // cycle never frees a slot for an incoming write.
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign out_data  = mem_q[rd_ptr_q];

  assign push = in_valid & ~full;
  assign pop  = out_ready & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; empty entries are never observed because every
  // consumer of out_data is qualified by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: rtl/pe_ingress_port.sv
// -----------------------------------------------------------------------------
// pe_ingress_port
// Buffers flits from a PE and steers each head flit to the router, back to
// the PE receive side (self-addressed), or discards it (bad destination).
//   clk          : clock
//   rst          : asynchronous active-low reset
//   i_data       : PE flit, [31:24] destination, [23:0] payload
//   i_data_valid : PE flit valid
//   o_data_ready : port can accept a PE flit
//   o_data       : flit to router (0 when not valid)
//   o_data_valid : router flit valid
//   i_data_ready : router accepts the flit
//   o_loop_data  : self-addressed flit to PE receive side (0 when not valid)
//   o_loop_valid : loop flit valid
//   i_loop_ready : PE receive side accepts the loop flit
//   o_sent_count : flits forwarded to router or loop, saturating
//   o_drop_count : flits discarded, saturating
// -----------------------------------------------------------------------------
module pe_ingress_port
  import noc_pkg::*;
#(
  parameter int ADDRESS = 0,
  parameter int DEPTH   = 4,
  parameter int NUM_PE  = noc_pkg::NUM_PE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] i_data,
  input  logic              i_data_valid,
  output logic              o_data_ready,
  output logic [FLIT_W-1:0] o_data,
  output logic              o_data_valid,
  input  logic              i_data_ready,
  output logic [FLIT_W-1:0] o_loop_data,
  output logic              o_loop_valid,
  input  logic              i_loop_ready,
  output logic [15:0]       o_sent_count,
  output logic [15:0]       o_drop_count
);

  logic              ready_en_q;
  logic              fifo_in_ready;
  logic [FLIT_W-1:0] head_data;
  logic              head_valid;
  logic              head_ready;
  flit_class_e       head_cls;
  logic              net_v;
  logic              loop_v;
  logic              drop_v;
  logic              pop;
  logic [15:0]       sent_q, sent_d;
  logic [15:0]       drop_q, drop_d;

  // Holds o_data_ready low during reset and lets it rise on the first clock
  // edge after release, independent of the FIFO's own full flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_en_q <= 1'b0;
    else      ready_en_q <= 1'b1;
  end

  noc_flit_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_data   (i_data),
    .in_valid  (i_data_valid & ready_en_q),
    .in_ready  (fifo_in_ready),
    .out_data  (head_data),
    .out_valid (head_valid),
    .out_ready (head_ready)
  );

  assign o_data_ready = fifo_in_ready & ready_en_q;

  assign head_cls = classify(head_data[DEST_HI:DEST_LO], ADDRESS, NUM_PE);
  assign net_v    = head_valid & (head_cls == NET);
  assign loop_v   = head_valid & (head_cls == LOOP);
  assign drop_v   = head_valid & (head_cls == DROP);

  // A discarded head pops immediately so it never stalls the queue.
  always_comb begin
    head_ready = 1'b0;
    unique case (head_cls)
      NET:     head_ready = i_data_ready;
      LOOP:    head_ready = i_loop_ready;
      DROP:    head_ready = 1'b1;
      default: head_ready = 1'b0;
    endcase
  end

  assign pop = head_valid & head_ready;

  assign o_data_valid = net_v;
  assign o_loop_valid = loop_v;
  assign o_data       = net_v  ? head_data : '0;
  assign o_loop_data  = loop_v ? head_data : '0;

  always_comb begin
    sent_d = sent_q;
    drop_d = drop_q;
    if (pop && !drop_v && (sent_q != 16'hFFFF)) sent_d = sent_q + 16'd1;
    if (drop_v && (drop_q != 16'hFFFF))         drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sent_q <= '0;
      drop_q <= '0;
    end else begin
      sent_q <= sent_d;
      drop_q <= drop_d;
    end
  end

  assign o_sent_count = sent_q;
  assign o_drop_count = drop_q;

endmodule

// File: doc/pe_ingress_port.md
PE_INGRESS_PORT -- requirements
Module: pe_ingress_port

Interface
REQ-001 The block SHALL have parameter ADDRESS, default 0, giving the local PE address (0..15).
REQ-002 The block SHALL have parameter DEPTH, default 4, giving FIFO depth in flits (power of two, >=2).
REQ-003 The block SHALL have parameter NUM_PE, default 16, giving the number of valid destinations.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, with reset asynchronous and active-low.
REQ-006 The block SHALL have port i_data, input, 32 bits: the flit from the PE, with [31:24] the destination and [23:0] the payload.
REQ-007 The block SHALL have port i_data_valid, input, 1 bit: the PE flit is valid.
REQ-008 The block SHALL have port o_data_ready, output, 1 bit: the port accepts a PE flit.
REQ-009 The block SHALL have port o_data, output, 32 bits: the flit to the router.
REQ-010 The block SHALL have port o_data_valid, output, 1 bit: the router flit is valid.
REQ-011 The block SHALL have port i_data_ready, input, 1 bit: the router accepts the flit.
REQ-012 The block SHALL have port o_loop_data, output, 32 bits: the self-addressed flit returned to the PE receive side.
REQ-013 The block SHALL have port o_loop_valid, output, 1 bit: the loop flit is valid.
REQ-014 The block SHALL have port i_loop_ready, input, 1 bit: the PE receive side accepts the loop flit.
REQ-015 The block SHALL have port o_sent_count, output, 16 bits: flits forwarded to the router or the loop, saturating.
REQ-016 The block SHALL have port o_drop_count, output, 16 bits: flits dropped for invalid destination, saturating.

Function
REQ-017 A PE transfer SHALL occur on a rising edge when i_data_valid and o_data_ready are both 1.
REQ-018 o_data_ready SHALL equal NOT full, with no push-through when full, even if a pop occurs in the same cycle.
REQ-019 The FIFO SHALL be DEPTH entries with wrapping read/write pointers and an occupancy counter of width clog2(DEPTH)+1.
REQ-020 A flit pushed at edge N SHALL be classifiable at the head in cycle N+1, giving a minimum latency of 1 cycle.
REQ-021 Head classification SHALL be: dest >= NUM_PE -> DROP; dest == ADDRESS -> LOOP; otherwise -> NET.
REQ-022 In the NET case, o_data_valid SHALL be 1, o_data SHALL equal the head flit, and the flit SHALL pop when i_data_ready is 1.
REQ-023 In the LOOP case, o_loop_valid SHALL be 1, o_loop_data SHALL equal the head flit, and the flit SHALL pop when i_loop_ready is 1.
REQ-024 In the DROP case, the flit SHALL pop unconditionally in that cycle, and o_drop_count SHALL increment.
REQ-025 o_data_valid and o_loop_valid SHALL never both be 1.
REQ-026 Once a valid is asserted, the corresponding data and valid SHALL hold stable until that flit pops.
REQ-027 Flit order SHALL be preserved across all classes, so a stalled head blocks the flits behind it.
REQ-028 A simultaneous push and pop when not full SHALL leave occupancy unchanged.
REQ-029 Popping while empty SHALL be impossible, because valids and drop are qualified by NOT empty.
REQ-030 o_sent_count SHALL increment on each NET or LOOP pop and saturate at 16'hFFFF.
REQ-031 o_drop_count SHALL saturate at 16'hFFFF.
REQ-032 Payload bits [23:0] SHALL pass through unmodified.

Reset
REQ-033 While rst is 0, the block SHALL hold pointers, occupancy and both counters at 0, o_data_valid and o_loop_valid at 0, o_data and o_loop_data at 32'h0, and o_data_ready at 0.
REQ-034 o_data_ready SHALL rise in the first cycle after rst deasserts.
REQ-035 An assertion of rst mid-operation SHALL discard all buffered flits, and outputs SHALL go to reset values immediately (asynchronously).

Structure
REQ-036 A shared package noc_pkg SHALL hold FLIT_W=32, DEST_HI=31, DEST_LO=24, PAYLOAD_W=24, NUM_PE=16 and the class enum {NET, LOOP, DROP}.
REQ-037 The block SHALL instantiate exactly one sub-module, noc_flit_fifo (parameterised width/depth, with valid/ready on both sides); classification and counters SHALL reside in the top.

Verification
REQ-038 Scenario NET: with ADDRESS=3, push 32'h05_000001 while i_data_ready=1 -> o_data=32'h05_000001 and o_data_valid=1 one cycle later, and o_sent_count=1.
REQ-039 Scenario LOOP: with ADDRESS=3, push 32'h03_0000AA -> o_loop_valid=1 with o_loop_data=32'h03_0000AA, o_data_valid stays 0, and o_sent_count=1.
REQ-040 Scenario DROP: push 32'h10_000007 then 32'h02_000008 -> no valid for the first flit, o_drop_count=1, and the second flit appears on o_data afterwards.
REQ-041 Scenario backpressure: hold i_data_ready=0 and push 5 flits with DEPTH=4 -> o_data_ready=0 after 4 accepts, the head stays stable, and the first release delivers the flits in order.
REQ-042 Scenario mid-reset: assert rst with 3 flits buffered -> all valids=0 and counters=0 immediately, and no stale flit emerges after release.
REQ-043 Scenario saturation: force 65537 NET pops -> o_sent_count holds at 16'hFFFF.
